// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4-Stream definitions for the NoC endpoints: bus widths, the
// matching signal typedefs and a small helper for sizing beat counters.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 4;
  localparam int USER_WIDTH = 1;

  typedef logic [DATA_WIDTH-1:0] axi_data_t;
  typedef logic [KEEP_WIDTH-1:0] axi_keep_t;
  typedef logic [ID_WIDTH-1:0]   axi_id_t;
  typedef logic [DEST_WIDTH-1:0] axi_dest_t;
  typedef logic [USER_WIDTH-1:0] axi_user_t;

  // Width needed to hold a beat index 0..len (one spare code so len itself
  // is representable, which keeps the LEN=1 case at a legal width of 1).
  function automatic int beat_cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/axi_stream_interface.sv
// -----------------------------------------------------------------------------
// axi_stream_interface
// One AXI4-Stream link. The master modport drives the payload/sideband and
// samples tready; the slave modport is the mirror image.
// Signals: tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
// -----------------------------------------------------------------------------
interface axi_stream_interface;
  import axi4_pkg::*;

  logic      tvalid;
  logic      tready;
  axi_data_t tdata;
  axi_keep_t tstrb;
  axi_keep_t tkeep;
  logic      tlast;
  axi_id_t   tid;
  axi_dest_t tdest;
  axi_user_t tuser;

  modport master (
    output tvalid,
    input  tready,
    output tdata,
    output tstrb,
    output tkeep,
    output tlast,
    output tid,
    output tdest,
    output tuser
  );

  modport slave (
    input  tvalid,
    output tready,
    input  tdata,
    input  tstrb,
    input  tkeep,
    input  tlast,
    input  tid,
    input  tdest,
    input  tuser
  );

endinterface

// File: rtl/axis_master_device.sv
// -----------------------------------------------------------------------------
// axis_master_device
// AXI4-Stream traffic generator. When idle and start is high it latches dest
// and emits LEN beats carrying BASE_DATA+i (i = 0..LEN-1), tagged with TID=ID,
// tlast on the final beat. Start is ignored while a packet is in flight.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   start  in   level; launches a packet when sampled high in IDLE
//   dest   in   destination node, captured at launch
//   axis   master side of axi_stream_interface
// -----------------------------------------------------------------------------
module axis_master_device
  import axi4_pkg::*;
#(
  parameter int        ID        = 0,
  parameter int        LEN       = 24,
  parameter axi_data_t BASE_DATA = 64'hdeadbeef00000000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  axi_dest_t            dest,
  axi_stream_interface.master  axis
);

  localparam int CNT_W = beat_cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  axi_dest_t        dest_q,  dest_d;

  logic sending;
  logic last_beat;

  // tvalid is a pure function of state, never of tready, and all payload
  // fields derive from registers only, so they hold while stalled.
  assign sending   = (state_q == ST_SEND);
  assign last_beat = sending && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          dest_d  = dest;
        end
      end
      ST_SEND: begin
        if (axis.tready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  // Payload is gated to zero outside SEND so an idle link shows tdata=0.
  // The add is full 64-bit and wraps naturally.
  assign axis.tvalid = sending;
  assign axis.tdata  = sending ? (BASE_DATA + DATA_WIDTH'(cnt_q)) : '0;
  assign axis.tlast  = last_beat;
  assign axis.tdest  = dest_q;
  assign axis.tid    = ID_WIDTH'(ID);
  assign axis.tstrb  = '1;
  assign axis.tkeep  = '1;
  assign axis.tuser  = '0;

endmodule

// File: tb/tb_axis_master_device.sv
// Randomised bench for axis_master_device. Three instances share start/dest
// but have independent tready: the default 24-beat device, a 3-beat device
// whose payload wraps past 2^64, and a single-beat device.
module tb_axis_master_device;
  import axi4_pkg::*;

  localparam int NI = 3;
  localparam int        LEN0 = 24, LEN1 = 3, LEN2 = 1;
  localparam int        ID0  = 0,  ID1  = 3, ID2  = 1;
  localparam axi_data_t BASE0 = 64'hdeadbeef00000000;
  localparam axi_data_t BASE1 = 64'hfffffffffffffffe;
  localparam axi_data_t BASE2 = 64'h0123456789abcdef;

  int        len_a  [NI] = '{LEN0, LEN1, LEN2};
  int        id_a   [NI] = '{ID0, ID1, ID2};
  axi_data_t base_a [NI] = '{BASE0, BASE1, BASE2};

  logic      clk = 1'b0;
  logic      rst_n;
  logic      start;
  axi_dest_t dest;
  logic [NI-1:0] rdy;

  axi_stream_interface axis0 ();
  axi_stream_interface axis1 ();
  axi_stream_interface axis2 ();

  axis_master_device #(.ID(ID0), .LEN(LEN0), .BASE_DATA(BASE0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .start(start), .dest(dest), .axis(axis0));
  axis_master_device #(.ID(ID1), .LEN(LEN1), .BASE_DATA(BASE1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .start(start), .dest(dest), .axis(axis1));
  axis_master_device #(.ID(ID2), .LEN(LEN2), .BASE_DATA(BASE2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .start(start), .dest(dest), .axis(axis2));

  always #5 clk = ~clk;

  assign axis0.tready = rdy[0];
  assign axis1.tready = rdy[1];
  assign axis2.tready = rdy[2];

  logic [NI-1:0] vld, lst;
  axi_data_t     dat  [NI];
  axi_keep_t     kp   [NI];
  axi_keep_t     sb   [NI];
  axi_id_t       tid  [NI];
  axi_dest_t     tdst [NI];
  axi_user_t     usr  [NI];

  assign vld[0] = axis0.tvalid; assign lst[0] = axis0.tlast; assign dat[0] = axis0.tdata;
  assign kp[0]  = axis0.tkeep;  assign sb[0]  = axis0.tstrb; assign tid[0] = axis0.tid;
  assign tdst[0] = axis0.tdest; assign usr[0] = axis0.tuser;
  assign vld[1] = axis1.tvalid; assign lst[1] = axis1.tlast; assign dat[1] = axis1.tdata;
  assign kp[1]  = axis1.tkeep;  assign sb[1]  = axis1.tstrb; assign tid[1] = axis1.tid;
  assign tdst[1] = axis1.tdest; assign usr[1] = axis1.tuser;
  assign vld[2] = axis2.tvalid; assign lst[2] = axis2.tlast; assign dat[2] = axis2.tdata;
  assign kp[2]  = axis2.tkeep;  assign sb[2]  = axis2.tstrb; assign tid[2] = axis2.tid;
  assign tdst[2] = axis2.tdest; assign usr[2] = axis2.tuser;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each device is either idle or part-way through a
  // packet (beat index + captured destination). Accepted payloads go to a
  // per-device scoreboard that is checked as a whole when the packet ends.
  bit        busy   [NI];
  int        idx    [NI];
  axi_dest_t ldest  [NI];
  bit        stalled[NI];
  axi_data_t held   [NI];
  axi_data_t seen   [NI];
  axi_data_t acc_q  [NI][$];
  int        pkts   [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      busy[i] = 0; idx[i] = 0; ldest[i] = '0; stalled[i] = 0; acc_q[i].delete();
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      seen[i] = dat[i];
      check_eq($sformatf("tvalid%0d", i), 64'(vld[i]), 64'(busy[i]));
      check_eq($sformatf("tid%0d", i), 64'(tid[i]), 64'(id_a[i]));
      check_eq($sformatf("tkeep%0d", i), 64'(kp[i]), 64'hff);
      check_eq($sformatf("tstrb%0d", i), 64'(sb[i]), 64'hff);
      check_eq($sformatf("tuser%0d", i), 64'(usr[i]), 64'h0);
      if (busy[i]) begin
        check_eq($sformatf("tdata%0d", i), dat[i], base_a[i] + 64'(idx[i]));
        check_eq($sformatf("tlast%0d", i), 64'(lst[i]), 64'(idx[i] == len_a[i] - 1));
        check_eq($sformatf("tdest%0d", i), 64'(tdst[i]), 64'(ldest[i]));
      end
      if (stalled[i])
        check_eq($sformatf("stable%0d", i), dat[i], held[i]);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      stalled[i] = busy[i] && !rdy[i];
      held[i]    = seen[i];
      if (busy[i]) begin
        if (rdy[i]) begin
          acc_q[i].push_back(seen[i]);
          if (idx[i] == len_a[i] - 1) begin
            busy[i] = 0;
            pkts[i]++;
            check_eq($sformatf("pktlen%0d", i), 64'(acc_q[i].size()), 64'(len_a[i]));
            for (int k = 0; k < acc_q[i].size(); k++)
              check_eq($sformatf("pkt%0d_beat%0d", i, k), acc_q[i][k], base_a[i] + 64'(k));
            $display("packet dev%0d #%0d dest=%0d beats=%0d", i, pkts[i], ldest[i], acc_q[i].size());
            acc_q[i].delete();
          end else begin
            idx[i]++;
          end
        end
      end else if (start) begin
        busy[i] = 1; idx[i] = 0; ldest[i] = dest; acc_q[i].delete();
      end
    end
  endtask

  task automatic step(input logic st, input axi_dest_t d, input logic [NI-1:0] r);
    @(negedge clk);
    check_outputs();
    start = st; dest = d; rdy = r;
    @(posedge clk);
    model_update();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NI; i++) pkts[i] = 0;
    rst_n = 1'b0; start = 1'b0; dest = '0; rdy = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst_tvalid%0d", i), 64'(vld[i]), 64'h0);
      check_eq($sformatf("rst_tlast%0d", i), 64'(lst[i]), 64'h0);
      check_eq($sformatf("rst_tdata%0d", i), dat[i], 64'h0);
      check_eq($sformatf("rst_tdest%0d", i), 64'(tdst[i]), 64'h0);
    end
    rst_n = 1'b1;

    // Basic packet, dest=2, one-cycle start pulse, always ready.
    step(1'b1, 4'd2, '1);
    repeat (30) step(1'b0, 4'd2, '1);

    // Start pulse and dest change during beat 10 must be ignored.
    step(1'b1, 4'd2, '1);
    guard = 0;
    while (!(busy[0] && idx[0] == 10) && guard < 100) begin step(1'b0, 4'd2, '1); guard++; end
    check_eq("beat10_wait", 64'(idx[0]), 64'd10);
    step(1'b1, 4'd3, '1);
    repeat (20) step(1'b0, 4'd3, '1);

    // Random backpressure, sporadic starts, wandering dest.
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 7) == 0), axi_dest_t'($urandom_range(0, 15)), NI'($urandom));
    repeat (40) step(1'b0, 4'd0, '1);

    // Asynchronous reset at beat 5 of the long packet.
    step(1'b1, 4'd2, '1);
    guard = 0;
    while (!(busy[0] && idx[0] == 5) && guard < 100) begin step(1'b0, 4'd2, '1); guard++; end
    check_eq("beat5_wait", 64'(idx[0]), 64'd5);
    @(negedge clk);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("async_rst_tvalid%0d", i), 64'(vld[i]), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd2, '1);
    repeat (30) step(1'b0, 4'd2, '1);

    // Start held high: back-to-back packets with one idle cycle between.
    for (int n = 0; n < 120; n++) step(1'b1, 4'd1, '1);
    repeat (30) step(1'b0, 4'd1, '1);

    check_eq("dev0_packets_seen", 64'(pkts[0] > 5), 64'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
